kernel_seq: RTL
===============

KERNEL_SEQ -- requirements
Module: kernel_seq

Interface
REQ-001 Parameter N_PIX, default 9, SHALL set the number of pixel acquisitions per kernel (2..15).
REQ-002 Parameter DW, default 10, SHALL set the ADC sample width in bits.
REQ-003 clk  input  1  SHALL be the clock; all state changes on rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 kernel_start_i  input  1  SHALL request one kernel acquisition; sampled only in IDLE.
REQ-006 pxl_done_i  input  1  SHALL be the pixel-FSM one-cycle done pulse.
REQ-007 adc_valid_i  input  1  SHALL qualify adc_data_i for one cycle.
REQ-008 adc_data_i  input  DW  SHALL be the sampled pixel value.
REQ-009 tmo_max_i  input  10  SHALL be the per-pixel timeout in clk cycles; 0 disables it.
REQ-010 rd_addr_i  input  4  SHALL be the result buffer read address.
REQ-011 pxl_start_o  output  1  SHALL be the one-cycle start pulse to the pixel FSM.
REQ-012 pxl_sel_o  output  4  SHALL be the index of the pixel currently being acquired.
REQ-013 busy_o  output  1  SHALL be high in every state except IDLE.
REQ-014 kernel_done_o  output  1  SHALL be a one-cycle pulse on kernel completion.
REQ-015 miss_mask_o  output  N_PIX  SHALL flag pixels that completed without a sample.
REQ-016 err_o  output  1  SHALL flag a timeout abort.
REQ-017 rd_data_o  output  DW  SHALL be the buffer entry at rd_addr_i.

Function
REQ-018 States SHALL be IDLE, START, WAIT, DONE and ERR; outputs decoded from the registered state.
REQ-019 IDLE with kernel_start_i=1 SHALL go to START, clearing pxl_sel_o, miss_mask_o and err_o.
REQ-020 kernel_start_i while busy_o=1 SHALL be ignored.
REQ-021 START SHALL assert pxl_start_o for exactly one cycle, then go to WAIT.
REQ-022 First adc_valid_i in WAIT SHALL write adc_data_i to buffer[pxl_sel_o]; later valids for the same pixel are ignored.
REQ-023 adc_valid_i outside WAIT SHALL be ignored.
REQ-024 pxl_done_i in WAIT with no sample taken SHALL write 0 to buffer[pxl_sel_o] and set miss_mask_o[pxl_sel_o].
REQ-025 adc_valid_i and pxl_done_i in the same cycle SHALL count as sampled; the data is stored and no miss is flagged.
REQ-026 pxl_done_i in WAIT with pxl_sel_o<N_PIX-1 SHALL increment pxl_sel_o and go to START.
REQ-027 pxl_done_i in WAIT with pxl_sel_o=N_PIX-1 SHALL go to DONE; pxl_sel_o does not wrap.
REQ-028 DONE SHALL assert kernel_done_o for one cycle, then go to IDLE.
REQ-029 pxl_done_i outside WAIT SHALL be ignored.
REQ-030 Start to first pxl_start_o SHALL be 1 cycle; pxl_done_i to next pxl_start_o SHALL be 1 cycle.
REQ-031 rd_data_o SHALL be registered (1-cycle latency); rd_addr_i>=N_PIX SHALL return 0.
REQ-032 Buffer contents SHALL persist until overwritten by a later kernel.

Reset
REQ-033 Reset SHALL force IDLE and drive pxl_start_o=0, pxl_sel_o=0, busy_o=0, kernel_done_o=0, miss_mask_o=0, err_o=0, rd_data_o=0.
REQ-034 Reset SHALL clear every buffer entry to 0.
REQ-035 Reset during any state SHALL abort the kernel with no kernel_done_o pulse.

Configuration
REQ-036 The per-pixel timeout watchdog SHALL be controlled by the macro KSEQ_TIMEOUT_EN.
REQ-037 With KSEQ_TIMEOUT_EN defined, a 10-bit counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-038 With the counter at tmo_max_i (nonzero) and no pxl_done_i, the FSM SHALL go to ERR, set err_o and set miss_mask_o[pxl_sel_o].
REQ-039 ERR SHALL last one cycle, then go to IDLE with no kernel_done_o; err_o holds until the next accepted kernel_start_i or reset.
REQ-040 pxl_done_i in the timeout cycle SHALL take priority over the timeout.
REQ-041 Without KSEQ_TIMEOUT_EN, no counter SHALL be built, ERR is unreachable, err_o is tied to 0 and tmo_max_i is ignored.

Verification
REQ-042 Nominal: kernel_start pulse, 9 pixels each done 20 cycles after start with adc_data=0x100+idx -> 9 pxl_start pulses, kernel_done once, miss_mask=0, rd_addr 4 -> 0x104 after 1 cycle.
REQ-043 Miss: pixel 3 done without adc_valid -> buffer[3]=0, miss_mask=0x008, kernel still completes.
REQ-044 Same cycle: adc_valid=1 (data 0x3FF) and pxl_done=1 together on pixel 8 -> buffer[8]=0x3FF, kernel_done next cycle.
REQ-045 Timeout (macro on): tmo_max=50, pixel 2 never done -> ERR after 50 WAIT cycles, err_o=1, miss_mask=0x004, no kernel_done; macro off -> remains in WAIT.
REQ-046 Abuse: kernel_start re-pulsed mid-kernel -> ignored; reset asserted in WAIT of pixel 5 -> all outputs 0 immediately, buffer cleared, no kernel_done.

Source files
------------

// File: rtl/kernel_seq.sv
// kernel_seq: steps through N_PIX pixel acquisitions and keeps one ADC sample per pixel.
// Optional per-pixel timeout watchdog is built only when KSEQ_TIMEOUT_EN is defined.
module kernel_seq #(
  parameter int N_PIX = 9,
  parameter int DW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kernel_start_i,
  input  logic             pxl_done_i,
  input  logic             adc_valid_i,
  input  logic [DW-1:0]    adc_data_i,
  input  logic [9:0]       tmo_max_i,
  input  logic [3:0]       rd_addr_i,
  output logic             pxl_start_o,
  output logic [3:0]       pxl_sel_o,
  output logic             busy_o,
  output logic             kernel_done_o,
  output logic [N_PIX-1:0] miss_mask_o,
  output logic             err_o,
  output logic [DW-1:0]    rd_data_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERR} state_t;
  localparam logic [3:0] LAST_SEL = 4'(N_PIX - 1);

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic             sampled_q, sampled_d;
  logic [N_PIX-1:0] miss_q;
  logic [DW-1:0]    entry_rd [N_PIX];
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             accept_start, in_wait, wr_en, miss_set, tmo_hit;
  logic [DW-1:0]    wr_data;

  assign accept_start = (state_q == S_IDLE) && kernel_start_i;
  assign in_wait      = (state_q == S_WAIT);

`ifdef KSEQ_TIMEOUT_EN
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  // The count of completed WAIT cycles reaches tmo_max_i on this edge; a done pulse wins.
  assign tmo_hit = in_wait && !pxl_done_i && (tmo_max_i != 10'd0) &&
                   ((tmo_cnt_q + 10'd1) == tmo_max_i);

  always_comb begin
    tmo_cnt_d = in_wait ? tmo_cnt_q + 10'd1 : 10'd0;
    err_d     = err_q;
    if (accept_start) err_d = 1'b0;
    else if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= 10'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_max_i;
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (kernel_start_i) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (pxl_done_i)   state_d = (sel_q == LAST_SEL) ? S_DONE : S_START;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pxl_start_o   = (state_q == S_START);
    busy_o        = (state_q != S_IDLE);
    kernel_done_o = (state_q == S_DONE);
  end

  // Only the first sample of a pixel is stored; a done with no sample stores 0 and flags a miss.
  always_comb begin
    sel_d     = sel_q;
    sampled_d = sampled_q;
    wr_en     = 1'b0;
    wr_data   = adc_data_i;
    miss_set  = 1'b0;
    if (accept_start)       sel_d     = 4'd0;
    if (state_q == S_START) sampled_d = 1'b0;
    if (in_wait) begin
      if (adc_valid_i && !sampled_q) begin
        wr_en     = 1'b1;
        sampled_d = 1'b1;
      end else if (pxl_done_i && !sampled_q) begin
        wr_en    = 1'b1;
        wr_data  = '0;
        miss_set = 1'b1;
      end
      if (tmo_hit) miss_set = 1'b1;
      if (pxl_done_i && (sel_q != LAST_SEL)) sel_d = sel_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= 4'd0;
      sampled_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      sel_q     <= sel_d;
      sampled_q <= sampled_d;
      rd_data_q <= rd_data_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PIX; gi++) begin : g_entry
      logic [DW-1:0] entry_q;
      logic          miss_bit_q;
      logic          hit;

      assign hit = (sel_q == 4'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q    <= '0;
          miss_bit_q <= 1'b0;
        end else begin
          if (wr_en && hit) entry_q <= wr_data;
          if (accept_start)         miss_bit_q <= 1'b0;
          else if (miss_set && hit) miss_bit_q <= 1'b1;
        end
      end

      assign entry_rd[gi] = entry_q;
      assign miss_q[gi]   = miss_bit_q;
    end
  endgenerate

  // Addresses past the last pixel read back as zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (rd_addr_i == 4'(i)) rd_data_d = entry_rd[i];
    end
  end

  assign pxl_sel_o   = sel_q;
  assign miss_mask_o = miss_q;
  assign rd_data_o   = rd_data_q;
endmodule
